// File: rtl/maze_map_ram.sv
// Writable two-plane maze map: wall plane loaded by row, pellet plane derived by a
// one-row-per-cycle reload sequencer, with a single-pellet eat handshake and level-clear.
module maze_map_ram #(
    parameter int unsigned COLS   = 32,
    parameter int unsigned ROWS   = 32,
    parameter int unsigned COL_AW = 5,
    parameter int unsigned ROW_AW = 5,
    parameter int unsigned CNT_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ROW_AW-1:0] row_addr,
    output logic [COLS-1:0]   wall_bits,
    output logic [COLS-1:0]   pellet_bits,
    input  logic              wall_we,
    input  logic [ROW_AW-1:0] wall_row,
    input  logic [COLS-1:0]   wall_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              eat_valid,
    output logic              eat_ready,
    input  logic [COL_AW-1:0] eat_x,
    input  logic [ROW_AW-1:0] eat_y,
    output logic              ate,
    output logic [CNT_W-1:0]  pellet_count,
    output logic              level_clear
);

    typedef enum logic [1:0] {IDLE, RELOAD, FINISH} state_t;

    state_t             state;
    logic [COLS-1:0]    wall_mem   [ROWS];
    logic [COLS-1:0]    pellet_mem [ROWS];
    logic [ROW_AW-1:0]  r;
    logic [CNT_W-1:0]   acc;
    logic               loaded;

    logic               row_ok;
    logic               wall_row_ok;
    logic               eat_in_range;
    logic               eat_hit;
    logic [COL_AW-1:0]  eat_bit;

    // Out-of-range rows read as solid wall with no pellets.
    assign row_ok      = {1'b0, row_addr} < (ROW_AW+1)'(ROWS);
    assign wall_bits   = row_ok ? wall_mem[row_addr]   : '1;
    assign pellet_bits = row_ok ? pellet_mem[row_addr] : '0;

    assign wall_row_ok  = {1'b0, wall_row} < (ROW_AW+1)'(ROWS);
    assign eat_ready    = (state == IDLE) && !start;
    assign eat_bit      = COL_AW'(COLS-1) - eat_x;
    assign eat_in_range = ({1'b0, eat_x} < (COL_AW+1)'(COLS)) &&
                          ({1'b0, eat_y} < (ROW_AW+1)'(ROWS));
    assign eat_hit      = eat_valid && eat_ready && eat_in_range &&
                          pellet_mem[eat_y][eat_bit];

    assign level_clear  = loaded && (pellet_count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            r            <= '0;
            acc          <= '0;
            loaded       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ate          <= 1'b0;
            pellet_count <= '0;
            for (int unsigned i = 0; i < ROWS; i++) begin
                wall_mem[i]   <= '0;
                pellet_mem[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            ate  <= 1'b0;

            if (state == IDLE && wall_we && wall_row_ok)
                wall_mem[wall_row] <= wall_data;

            // Eats only fire in IDLE, so they never collide with reload row writes.
            if (eat_hit) begin
                pellet_mem[eat_y][eat_bit] <= 1'b0;
                ate <= 1'b1;
                if (pellet_count != '0)
                    pellet_count <= pellet_count - CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RELOAD;
                        r      <= '0;
                        acc    <= '0;
                        loaded <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                RELOAD: begin
                    pellet_mem[r] <= ~wall_mem[r];
                    acc <= acc + CNT_W'($countones(~wall_mem[r]));
                    r   <= r + ROW_AW'(1);
                    if (r == ROW_AW'(ROWS-1)) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    pellet_count <= acc;
                    loaded       <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_map_ram.sv
// Directed + randomized bench for maze_map_ram against a tile-level reference model.
module tb_maze_map_ram;

    localparam int COLS   = 32;
    localparam int ROWS   = 32;
    localparam int COL_AW = 5;
    localparam int ROW_AW = 5;
    localparam int CNT_W  = 11;

    logic              clk = 1'b0;
    logic              reset;
    logic [ROW_AW-1:0] row_addr;
    logic [COLS-1:0]   wall_bits, pellet_bits;
    logic              wall_we;
    logic [ROW_AW-1:0] wall_row;
    logic [COLS-1:0]   wall_data;
    logic              start, busy, done;
    logic              eat_valid, eat_ready, ate;
    logic [COL_AW-1:0] eat_x;
    logic [ROW_AW-1:0] eat_y;
    logic [CNT_W-1:0]  pellet_count;
    logic              level_clear;

    int checks   = 0;
    int failures = 0;

    // Reference model: one flag per tile, indexed [row][column].
    bit ref_wall [ROWS][COLS];
    bit ref_pel  [ROWS][COLS];
    int ref_count;
    bit ref_loaded;

    maze_map_ram #(.COLS(COLS), .ROWS(ROWS), .COL_AW(COL_AW), .ROW_AW(ROW_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .row_addr(row_addr),
        .wall_bits(wall_bits), .pellet_bits(pellet_bits),
        .wall_we(wall_we), .wall_row(wall_row), .wall_data(wall_data),
        .start(start), .busy(busy), .done(done),
        .eat_valid(eat_valid), .eat_ready(eat_ready), .eat_x(eat_x), .eat_y(eat_y),
        .ate(ate), .pellet_count(pellet_count), .level_clear(level_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wall_word(input int y);
        logic [31:0] w = '0;
        for (int x = 0; x < COLS; x++) w[COLS-1-x] = ref_wall[y][x];
        return w;
    endfunction

    function automatic logic [31:0] pel_word(input int y);
        logic [31:0] w = '0;
        for (int x = 0; x < COLS; x++) w[COLS-1-x] = ref_pel[y][x];
        return w;
    endfunction

    function automatic void model_reset();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                ref_wall[y][x] = 1'b0;
                ref_pel[y][x]  = 1'b0;
            end
        ref_count  = 0;
        ref_loaded = 1'b0;
    endfunction

    function automatic void model_reload();
        ref_count = 0;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                ref_pel[y][x] = !ref_wall[y][x];
                if (ref_pel[y][x]) ref_count++;
            end
        ref_loaded = 1'b1;
    endfunction

    function automatic void model_set_wall(input int y, input logic [31:0] data);
        for (int x = 0; x < COLS; x++) ref_wall[y][x] = data[COLS-1-x];
    endfunction

    task automatic write_row(input int y, input logic [31:0] data);
        wall_we = 1'b1; wall_row = ROW_AW'(y); wall_data = data;
        tick();
        wall_we = 1'b0;
        model_set_wall(y, data);
    endtask

    task automatic check_row(input string tag, input int y);
        row_addr = ROW_AW'(y);
        #1;
        check({tag, "_wall"}, wall_bits, wall_word(y));
        check({tag, "_pellet"}, pellet_bits, pel_word(y));
    endtask

    task automatic check_idle_flags(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_count"}, 32'(pellet_count), 32'(ref_count));
        check({tag, "_clear"}, 32'(level_clear), 32'(ref_loaded && ref_count == 0));
    endtask

    // Pulse start (optionally with a same-cycle eat), optionally poke writes/start mid-reload.
    task automatic do_reload(input bit with_eat, input bit inject);
        int k = 0, busy_n = 0, done_k = -1;
        start = 1'b1;
        if (with_eat) begin
            eat_valid = 1'b1; eat_x = 5'd7; eat_y = 5'd9;
            #1;
            check("start_eat_ready", 32'(eat_ready), 32'd0);
        end
        tick();
        start = 1'b0;
        eat_valid = 1'b0;
        ref_loaded = 1'b0;
        if (with_eat) check("start_eat_ate", 32'(ate), 32'd0);
        check("reload_clear_drop", 32'(level_clear), 32'd0);
        while (busy && k < 100) begin
            busy_n++;
            if (done) done_k = k;
            if (inject && k == 5) begin
                wall_we = 1'b1; wall_row = 5'd3; wall_data = ~wall_word(3); start = 1'b1;
            end
            tick();
            wall_we = 1'b0; start = 1'b0;
            k++;
        end
        model_reload();
        check("reload_busy_cycles", 32'(busy_n), 32'(ROWS + 1));
        check("reload_done_cycle", 32'(done_k), 32'(ROWS));
        check("reload_count", 32'(pellet_count), 32'(ref_count));
        check("reload_clear", 32'(level_clear), 32'(ref_count == 0));
    endtask

    // Eat at (x,y), optionally with a concurrent wall write.
    task automatic eat(input int x, input int y, input bit we, input int wrow, input logic [31:0] wdata);
        bit hit = ref_pel[y][x];
        eat_valid = 1'b1; eat_x = COL_AW'(x); eat_y = ROW_AW'(y);
        wall_we = we; wall_row = ROW_AW'(wrow); wall_data = wdata;
        row_addr = ROW_AW'(y);
        #1;
        check("eat_ready", 32'(eat_ready), 32'd1);
        tick();
        eat_valid = 1'b0; wall_we = 1'b0;
        if (hit) begin
            ref_pel[y][x] = 1'b0;
            if (ref_count > 0) ref_count--;
        end
        if (we) model_set_wall(wrow, wdata);
        check("eat_ate", 32'(ate), 32'(hit));
        check("eat_count", 32'(pellet_count), 32'(ref_count));
        check("eat_row", pellet_bits, pel_word(y));
        tick();
        check("eat_ate_pulse", 32'(ate), 32'd0);
    endtask

    initial begin
        reset = 1'b1; row_addr = '0; wall_we = 1'b0; wall_row = '0; wall_data = '0;
        start = 1'b0; eat_valid = 1'b0; eat_x = '0; eat_y = '0;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check_row("rst_r0", 0);
        check_row("rst_r31", 31);
        check_idle_flags("rst");
        check("rst_done", 32'(done), 32'd0);
        check("rst_ate", 32'(ate), 32'd0);
        check("rst_eat_ready", 32'(eat_ready), 32'd1);

        // Directed level: solid walls except row 2
        for (int y = 0; y < ROWS; y++) write_row(y, (y == 2) ? 32'hF000C003 : 32'hFFFFFFFF);
        check_row("load_r2", 2);
        do_reload(1'b0, 1'b0);
        check("dir_count24", 32'(pellet_count), 32'd24);
        row_addr = 5'd2; #1;
        check("dir_row2", pellet_bits, 32'h0FFF3FFC);

        eat(4, 2, 1'b0, 0, '0);
        check("dir_count23", 32'(pellet_count), 32'd23);
        check("dir_row2_eaten", pellet_bits, 32'h07FF3FFC);
        eat(4, 2, 1'b0, 0, '0);

        // Clear the level, then eat on a wall
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                if (ref_pel[y][x]) eat(x, y, 1'b0, 0, '0);
        check("level_clear_set", 32'(level_clear), 32'd1);
        eat(0, 0, 1'b0, 0, '0);
        check_idle_flags("after_clear");

        // Random level; start+eat collision; writes/start during reload ignored
        for (int y = 0; y < ROWS; y++) write_row(y, $urandom() & $urandom());
        do_reload(1'b1, 1'b1);
        for (int y = 0; y < ROWS; y++) check_row("rand_rows", y);

        // Random eats, some with concurrent wall writes
        for (int i = 0; i < 60; i++) begin
            int x = $urandom_range(COLS-1);
            int y = $urandom_range(ROWS-1);
            bit we = ($urandom_range(3) == 0);
            eat(x, y, we, $urandom_range(ROWS-1), $urandom());
        end
        for (int y = 0; y < ROWS; y++) check_row("rand_eat_rows", y);
        check_idle_flags("rand_eat");

        // Reset in the middle of a reload
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        #1;
        model_reset();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_count", 32'(pellet_count), 32'd0);
        check("midrst_clear", 32'(level_clear), 32'd0);
        row_addr = 5'd0; #1;
        check("midrst_wall", wall_bits, 32'd0);
        check("midrst_pellet", pellet_bits, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("midrst_eat_ready", 32'(eat_ready), 32'd1);

        for (int y = 0; y < ROWS; y++) write_row(y, $urandom() | $urandom());
        do_reload(1'b0, 1'b0);
        for (int y = 0; y < ROWS; y += 5) check_row("post_rst_rows", y);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
